// File: rtl/scope_pkg.sv
// Shared constants, FSM state type and the ADC-to-screen-row conversion
// for the scope capture stage.
package scope_pkg;

  localparam int ADC_W = 14;
  localparam int DEPTH = 160;
  localparam int Y_MAX = 119;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READY} state_t;

  // Top 7 ADC bits select a row; full scale maps to row 0, clamped at Y_MAX.
  function automatic logic [7:0] adc_to_y(input logic [ADC_W-1:0] sample);
    logic [6:0] c;
    c = sample[ADC_W-1:ADC_W-7];
    if (c >= 7'(Y_MAX)) return 8'd0;
    return 8'(Y_MAX) - {1'b0, c};
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Frame store: one write port for the capture side, one registered read
// port for the drawer. Columns past the frame read back as the bottom row.
module capture_ram
  import scope_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read with out-of-range columns forced to the bottom row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_addr < 8'(DEPTH)) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= 8'(Y_MAX);
    end
  end

endmodule

// File: rtl/scope_capture.sv
// Trigger, decimate and hold one frame of screen rows for the VGA drawer.
module scope_capture
  import scope_pkg::*;
#(
  parameter int TO_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  trig_level,
  input  logic [7:0]        decim,
  input  logic              auto_rearm,
  input  logic              arm,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_ready,
  input  logic              frame_done,
  output logic              triggered_auto
);

  // The counter reaches all-ones on the same edge that leaves ARMED.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t           state;
  state_t           next_state;
  logic [ADC_W-1:0] prev_p0;
  logic             prev_vld_p0;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       waddr;
  logic [7:0]       dcnt;
  logic [7:0]       decim_q;
  logic             crossing;
  logic             timeout;
  logic             start;
  logic             enter_armed;
  logic             we;
  logic             last_store;
  logic [7:0]       wdata;

  assign crossing = adc_valid && prev_vld_p0 &&
                    (prev_p0 < trig_level) && (adc_data >= trig_level);
  assign timeout  = (state == ARMED) && (to_cnt == TO_LAST);
  assign wdata    = adc_to_y(adc_data);

  // State register; frame_ready tracks the state it is entering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frame_ready <= 1'b0;
    end else begin
      state       <= next_state;
      frame_ready <= (next_state == READY);
    end
  end

  // Next-state selection; frame_done takes priority over a coincident arm.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (arm) next_state = ARMED;
      ARMED:   if (crossing || timeout) next_state = CAPTURE;
      CAPTURE: if (last_store) next_state = READY;
      READY:   if (frame_done) next_state = auto_rearm ? ARMED : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state strobes: entry to ARMED, capture start and RAM writes.
  always_comb begin
    we          = 1'b0;
    start       = 1'b0;
    enter_armed = 1'b0;
    last_store  = 1'b0;
    case (state)
      IDLE:    enter_armed = arm;
      ARMED: begin
        start = crossing || timeout;
        we    = start && adc_valid;
      end
      CAPTURE: begin
        we         = adc_valid && (dcnt == 8'd0);
        last_store = we && (waddr == 8'(DEPTH - 1));
      end
      READY:   enter_armed = frame_done && auto_rearm;
      default: ;
    endcase
  end

  // Timeout counter, trigger history valid flag and trigger-source flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt         <= '0;
      prev_vld_p0    <= 1'b0;
      triggered_auto <= 1'b0;
    end else begin
      if (enter_armed) begin
        to_cnt      <= '0;
        prev_vld_p0 <= 1'b0;
      end else if (state == ARMED) begin
        to_cnt <= to_cnt + 1'b1;
        if (adc_valid) prev_vld_p0 <= 1'b1;
      end
      if (start) triggered_auto <= !crossing;
    end
  end

  // Previous valid sample seen while armed.
  always_ff @(posedge clk) begin
    if ((state == ARMED) && adc_valid) prev_p0 <= adc_data;
  end

  // Write address and decimation phase; the start sample counts as phase 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr <= '0;
      dcnt  <= '0;
    end else if (state == ARMED) begin
      if (start && adc_valid) begin
        waddr <= 8'd1;
        dcnt  <= (decim == 8'd0) ? 8'd0 : 8'd1;
      end else begin
        waddr <= '0;
        dcnt  <= '0;
      end
    end else if ((state == CAPTURE) && adc_valid) begin
      if (we && (waddr != 8'(DEPTH - 1))) waddr <= waddr + 8'd1;
      dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
    end
  end

  // Decimation ratio is frozen for the whole frame at capture start.
  always_ff @(posedge clk) begin
    if (start) decim_q <= decim;
  end

  capture_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Directed sequence with randomized ADC valid pattern, checked against a
// sample-list reference model of trigger, timeout and decimation.
module tb_scope_capture;

  localparam int TO_W = 10;
  localparam int TO_N = (1 << TO_W) - 1;
  localparam int NE   = 4000;
  localparam int NCOL = 160;

  logic        clk;
  logic        reset;
  logic [13:0] adc_data;
  logic        adc_valid;
  logic [13:0] trig_level;
  logic [7:0]  decim;
  logic        auto_rearm;
  logic        arm;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_ready;
  logic        frame_done;
  logic        triggered_auto;

  int checks   = 0;
  int failures = 0;

  int vld [NE];
  int dat [NE];
  int exp_y [NCOL];
  int store_edge [NCOL];
  int trig_edge;
  int ready_edge;
  int exp_auto;

  scope_capture #(.TO_W(TO_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
    .trig_level     (trig_level),
    .decim          (decim),
    .auto_rearm     (auto_rearm),
    .arm            (arm),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_ready    (frame_ready),
    .frame_done     (frame_done),
    .triggered_auto (triggered_auto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int yref(input int s);
    int c;
    c = s / 128;
    return (c >= 119) ? 0 : 119 - c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Edge 0 is the entry edge (arm or frame_done); later edges carry the stream.
  task automatic gen(input int ramp, input int base, input int pre);
    int cnt;
    int v;
    cnt    = 0;
    vld[0] = 1;
    dat[0] = pre;
    for (int e = 1; e < NE; e++) begin
      vld[e] = ($urandom_range(3) != 0) ? 1 : 0;
      v = ramp ? base + cnt : base;
      dat[e] = (v > 16383) ? 16383 : v;
      if (vld[e] != 0) cnt++;
    end
  endtask

  task automatic model(input int lvl, input int d);
    int have_prev;
    int prev;
    int n;
    int k;
    have_prev = 0;
    prev      = 0;
    trig_edge = -1;
    exp_auto  = 0;
    for (int e = 1; e < NE && trig_edge < 0; e++) begin
      if (vld[e] != 0 && have_prev != 0 && prev < lvl && dat[e] >= lvl) begin
        trig_edge = e;
        exp_auto  = 0;
      end else if (e == TO_N) begin
        trig_edge = e;
        exp_auto  = 1;
      end
      if (vld[e] != 0) begin
        have_prev = 1;
        prev      = dat[e];
      end
    end
    n = 0;
    k = 0;
    for (int e = trig_edge; e < NE && n < NCOL; e++) begin
      if (vld[e] != 0) begin
        if (k % (d + 1) == 0) begin
          exp_y[n]      = yref(dat[e]);
          store_edge[n] = e;
          n++;
        end
        k++;
      end
    end
    ready_edge = (n == NCOL) ? store_edge[NCOL-1] : -1;
  endtask

  // Drives the precomputed stream; abort_n >= 0 stops right after that store.
  task automatic run(input string tag, input int kind, input int d, input int abort_n);
    int limit;
    int rise;
    int nv;
    decim = 8'(d);
    rise  = -1;
    if (ready_edge < 0) begin
      chk({tag, "_model_frame"}, 0, 1);
      return;
    end
    limit = (abort_n >= 0) ? store_edge[abort_n] : ready_edge + 4;
    for (int e = 0; e <= limit; e++) begin
      adc_valid  = vld[e][0];
      adc_data   = 14'(dat[e]);
      arm        = (kind == 0 && e == 0);
      frame_done = (kind == 1 && e == 0);
      @(posedge clk);
      @(negedge clk);
      if (e == 0) chk({tag, "_ready_low_on_entry"}, frame_ready, 0);
      if (frame_ready === 1'b1 && rise < 0) rise = e;
    end
    arm        = 1'b0;
    frame_done = 1'b0;
    if (abort_n < 0) begin
      chk({tag, "_ready_edge"}, rise, ready_edge);
      chk({tag, "_triggered_auto"}, triggered_auto, exp_auto);
      nv = 0;
      for (int e = trig_edge; e <= rise && e >= 0; e++) nv += vld[e];
      if (exp_auto == 0) chk({tag, "_valids_to_ready"}, nv, 1 + 159 * (d + 1));
    end
  endtask

  task automatic read_col(input string tag, input int a, input int expv);
    rd_addr   = 8'(a);
    adc_valid = 1'($urandom_range(1));
    adc_data  = 14'($urandom_range(16383));
    @(posedge clk);
    @(negedge clk);
    chk(tag, rd_data, expv);
  endtask

  task automatic read_frame(input string tag);
    for (int a = 0; a < NCOL; a++) read_col(tag, a, exp_y[a]);
  endtask

  // A crossing ramp that must not produce a frame because the block is idle.
  task automatic idle_watch(input string tag);
    int seen;
    seen = 0;
    gen(1, 14'h1F00, 14'h1EFF);
    for (int e = 0; e < 800; e++) begin
      adc_valid = vld[e][0];
      adc_data  = 14'(dat[e]);
      @(posedge clk);
      @(negedge clk);
      if (frame_ready === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    reset      = 1'b0;
    adc_data   = '0;
    adc_valid  = 1'b0;
    trig_level = 14'h2000;
    decim      = '0;
    auto_rearm = 1'b0;
    arm        = 1'b0;
    rd_addr    = '0;
    frame_done = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_frame_ready", frame_ready, 0);
    chk("reset_triggered_auto", triggered_auto, 0);
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b1;
    @(negedge clk);

    // Ramp crossing, no decimation.
    gen(1, 14'h1F00, 14'h1EFF);
    model(14'h2000, 0);
    run("ramp", 0, 0, -1);
    read_col("ramp_addr0_const", 0, 55);
    read_frame("ramp_col");
    read_col("oor_160", 160, 119);
    read_col("oor_255", 255, 119);

    // Auto re-arm into a decimated capture.
    auto_rearm = 1'b1;
    gen(1, 14'h1F00, 14'h1EFF);
    model(14'h2000, 3);
    run("decim", 1, 3, -1);
    read_frame("decim_col");

    // frame_done with arm in READY and no auto re-arm: must land in IDLE.
    auto_rearm = 1'b0;
    frame_done = 1'b1;
    arm        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_done = 1'b0;
    arm        = 1'b0;
    chk("done_to_idle_ready", frame_ready, 0);
    idle_watch("idle_no_capture");

    // Auto-trigger on a flat full-scale input.
    gen(0, 14'h3FFF, 14'h3FFF);
    model(14'h2000, 0);
    chk("auto_model_start", trig_edge, TO_N);
    run("auto", 0, 0, -1);
    read_frame("auto_col");

    // First sample after arming has no predecessor and cannot trigger.
    frame_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_done = 1'b0;
    gen(1, 14'h2000, 14'h1FFF);
    model(14'h2000, 1);
    run("noprev", 0, 1, -1);
    read_frame("noprev_col");

    // Reset in the middle of a capture.
    auto_rearm = 1'b1;
    gen(1, 14'h1F00, 14'h1EFF);
    model(14'h2000, 0);
    run("abort", 1, 0, 80);
    reset = 1'b0;
    #1;
    chk("abort_frame_ready", frame_ready, 0);
    chk("abort_triggered_auto", triggered_auto, 0);
    @(negedge clk);
    reset = 1'b1;
    read_col("abort_oor_200", 200, 119);
    idle_watch("abort_idle_no_capture");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
